// File: rtl/decoder_scan_n_if.sv
// Select/decode bundle for decoder_scan_n: request side (enable, mode, valid, binary)
// and decoded status (ready, one-hot, index, step/wrap pulses).
interface decoder_scan_n_if #(
    parameter int BIN_W = 2
);
    localparam int OUT_W = 2**BIN_W;

    logic             i_enable;
    logic             i_mode;
    logic             i_valid;
    logic             o_ready;
    logic [BIN_W-1:0] i_binary;
    logic [OUT_W-1:0] o_one_hot;
    logic [BIN_W-1:0] o_index;
    logic             o_step;
    logic             o_wrap;

    modport master (
        output i_enable, i_mode, i_valid, i_binary,
        input  o_ready, o_one_hot, o_index, o_step, o_wrap
    );

    modport slave (
        input  i_enable, i_mode, i_valid, i_binary,
        output o_ready, o_one_hot, o_index, o_step, o_wrap
    );
endinterface

// File: rtl/decoder_scan_n.sv
// Binary-to-one-hot decoder with optional auto-scan (DECODER_SCAN_EN); 1-cycle select latency.
// Selects accepted only in DIRECT (o_ready); requests in IDLE/SCAN are dropped, never queued.
module decoder_scan_n #(
    parameter int BIN_W = 2,
    parameter int DWELL = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    decoder_scan_n_if.slave bus
);
    localparam int OUT_W = 2**BIN_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

`ifdef DECODER_SCAN_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DIRECT = 2'd1, SCAN = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DIRECT = 2'd1} state_t;
`endif

    state_t           state, state_nxt;
    logic [BIN_W-1:0] index, index_nxt;
    logic [OUT_W-1:0] one_hot, one_hot_nxt;
    logic             mode;
    logic             accept;
    logic             step, step_nxt;
    logic             wrap, wrap_nxt;

`ifdef DECODER_SCAN_EN
    logic [CNT_W-1:0] dwell, dwell_nxt;
    assign mode = bus.i_mode;
`else
    assign mode = 1'b0;
`endif

    assign accept = bus.i_valid && (state == DIRECT) && bus.i_enable && !mode;

    always_comb begin
        state_nxt   = state;
        index_nxt   = index;
        step_nxt    = 1'b0;
        wrap_nxt    = 1'b0;
        one_hot_nxt = '0;
`ifdef DECODER_SCAN_EN
        dwell_nxt   = '0;
`endif
        if (!bus.i_enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = mode ? SCAN_OR_DIRECT() : DIRECT;
                DIRECT:  if (mode) state_nxt = SCAN_OR_DIRECT();
`ifdef DECODER_SCAN_EN
                SCAN:    if (!mode) state_nxt = DIRECT;
`endif
                default: state_nxt = IDLE;
            endcase
        end

        if (accept)
            index_nxt = bus.i_binary;

`ifdef DECODER_SCAN_EN
        // Dwell only runs while staying in SCAN; any exit or entry restarts it at zero.
        if (state == SCAN && state_nxt == SCAN) begin
            if (dwell == CNT_W'(DWELL - 1)) begin
                index_nxt = index + 1'b1;
                step_nxt  = 1'b1;
                wrap_nxt  = (index == {BIN_W{1'b1}});
            end else begin
                dwell_nxt = dwell + 1'b1;
            end
        end
`endif

        if (state_nxt != IDLE)
            one_hot_nxt[index_nxt] = 1'b1;
    end

    function automatic state_t SCAN_OR_DIRECT();
`ifdef DECODER_SCAN_EN
        return SCAN;
`else
        return DIRECT;
`endif
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            index   <= '0;
            one_hot <= '0;
            step    <= 1'b0;
            wrap    <= 1'b0;
`ifdef DECODER_SCAN_EN
            dwell   <= '0;
`endif
        end else begin
            state   <= state_nxt;
            index   <= index_nxt;
            one_hot <= one_hot_nxt;
            step    <= step_nxt;
            wrap    <= wrap_nxt;
`ifdef DECODER_SCAN_EN
            dwell   <= dwell_nxt;
`endif
        end
    end

    assign bus.o_ready   = (state == DIRECT);
    assign bus.o_one_hot = one_hot;
    assign bus.o_index   = index;
    assign bus.o_step    = step;
    assign bus.o_wrap    = wrap;
endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed bench for decoder_scan_n with BIN_W=2, DWELL=3; scan scenarios run when DECODER_SCAN_EN is set.
module tb_decoder_scan_n;
    logic i_clk = 1'b0;
    logic i_rst_n;
    int   tests_run = 0;
    int   tests_failed = 0;

    decoder_scan_n_if #(.BIN_W(2)) bus ();

    decoder_scan_n #(.BIN_W(2), .DWELL(3)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        bus.i_enable = 1'b1;
        bus.i_mode   = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_binary = 2'd0;
        i_rst_n      = 1'b0;
        #12;
        tests_run++;
        if (bus.o_one_hot !== 4'b0000) begin tests_failed++; $display("FAIL reset_one_hot: got %b expected 0000", bus.o_one_hot); end
        tests_run++;
        if (bus.o_index !== 2'd0) begin tests_failed++; $display("FAIL reset_index: got %0d expected 0", bus.o_index); end
        tests_run++;
        if (bus.o_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", bus.o_ready); end
        tests_run++;
        if ({bus.o_step, bus.o_wrap} !== 2'b00) begin tests_failed++; $display("FAIL reset_step_wrap: got %b expected 00", {bus.o_step, bus.o_wrap}); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        tests_run++;
        if (bus.o_ready !== 1'b1) begin tests_failed++; $display("FAIL first_edge_ready: got %b expected 1", bus.o_ready); end
        tests_run++;
        if (bus.o_one_hot !== 4'b0001) begin tests_failed++; $display("FAIL first_edge_one_hot: got %b expected 0001", bus.o_one_hot); end
    endtask

    task automatic test_direct();
        logic [3:0] exp_oh [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int b = 0; b < 4; b++) begin
            bus.i_valid  = 1'b1;
            bus.i_binary = 2'(b);
            tick();
            tests_run++;
            if (bus.o_one_hot !== exp_oh[b]) begin tests_failed++; $display("FAIL direct_one_hot[%0d]: got %b expected %b", b, bus.o_one_hot, exp_oh[b]); end
            tests_run++;
            if (bus.o_index !== 2'(b)) begin tests_failed++; $display("FAIL direct_index[%0d]: got %0d expected %0d", b, bus.o_index, b); end
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic test_idle_ignore();
        bus.i_enable = 1'b0;
        tick();
        tests_run++;
        if (bus.o_one_hot !== 4'b0000) begin tests_failed++; $display("FAIL idle_one_hot: got %b expected 0000", bus.o_one_hot); end
        tests_run++;
        if (bus.o_ready !== 1'b0) begin tests_failed++; $display("FAIL idle_ready: got %b expected 0", bus.o_ready); end
        bus.i_valid  = 1'b1;
        bus.i_binary = 2'd2;
        tick();
        tests_run++;
        if (bus.o_index !== 2'd3) begin tests_failed++; $display("FAIL idle_valid_ignored: got index %0d expected 3", bus.o_index); end
        bus.i_valid  = 1'b0;
        bus.i_enable = 1'b1;
        tick();
        tests_run++;
        if (bus.o_one_hot !== 4'b1000) begin tests_failed++; $display("FAIL idle_resume_one_hot: got %b expected 1000", bus.o_one_hot); end
        tests_run++;
        if (bus.o_ready !== 1'b1) begin tests_failed++; $display("FAIL idle_resume_ready: got %b expected 1", bus.o_ready); end
    endtask

`ifdef DECODER_SCAN_EN
    task automatic test_scan_wrap();
        logic [3:0] exp_oh [7] = '{4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        logic       exp_st [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       exp_wr [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        bus.i_mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            tests_run++;
            if (bus.o_one_hot !== exp_oh[i]) begin tests_failed++; $display("FAIL scan_one_hot[%0d]: got %b expected %b", i, bus.o_one_hot, exp_oh[i]); end
            tests_run++;
            if ({bus.o_step, bus.o_wrap} !== {exp_st[i], exp_wr[i]}) begin tests_failed++; $display("FAIL scan_step_wrap[%0d]: got %b expected %b", i, {bus.o_step, bus.o_wrap}, {exp_st[i], exp_wr[i]}); end
        end
        tests_run++;
        if (bus.o_ready !== 1'b0) begin tests_failed++; $display("FAIL scan_ready: got %b expected 0", bus.o_ready); end
    endtask

    task automatic test_scan_ignore();
        bus.i_valid  = 1'b1;
        bus.i_binary = 2'd2;
        tick();
        bus.i_valid  = 1'b0;
        tests_run++;
        if (bus.o_index !== 2'd1) begin tests_failed++; $display("FAIL scan_valid_ignored: got index %0d expected 1", bus.o_index); end
        tests_run++;
        if (bus.o_one_hot !== 4'b0010) begin tests_failed++; $display("FAIL scan_valid_one_hot: got %b expected 0010", bus.o_one_hot); end
    endtask

    task automatic test_disable_mid_dwell();
        logic [3:0] exp_oh [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
        bus.i_enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if ({bus.o_one_hot, bus.o_step} !== 5'b0000_0) begin tests_failed++; $display("FAIL disabled_out[%0d]: got %b expected 00000", i, {bus.o_one_hot, bus.o_step}); end
        end
        bus.i_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (bus.o_one_hot !== exp_oh[i]) begin tests_failed++; $display("FAIL rescan_one_hot[%0d]: got %b expected %b", i, bus.o_one_hot, exp_oh[i]); end
            tests_run++;
            if (bus.o_step !== (i == 3)) begin tests_failed++; $display("FAIL rescan_step[%0d]: got %b expected %b", i, bus.o_step, (i == 3)); end
        end
    endtask

    task automatic test_reset_mid_scan();
        tick();
        tests_run++;
        if (bus.o_index !== 2'd2) begin tests_failed++; $display("FAIL pre_reset_index: got %0d expected 2", bus.o_index); end
        #2;
        i_rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.o_one_hot !== 4'b0000) begin tests_failed++; $display("FAIL async_reset_one_hot: got %b expected 0000", bus.o_one_hot); end
        tests_run++;
        if (bus.o_index !== 2'd0) begin tests_failed++; $display("FAIL async_reset_index: got %0d expected 0", bus.o_index); end
        i_rst_n = 1'b1;
        tick();
        tests_run++;
        if ({bus.o_one_hot, bus.o_ready} !== 5'b0001_0) begin tests_failed++; $display("FAIL scan_after_reset: got %b expected 00010", {bus.o_one_hot, bus.o_ready}); end
        bus.i_mode = 1'b0;
        tick();
        tests_run++;
        if ({bus.o_one_hot, bus.o_ready, bus.o_step} !== 6'b0001_1_0) begin tests_failed++; $display("FAIL scan_abort: got %b expected 000110", {bus.o_one_hot, bus.o_ready, bus.o_step}); end
    endtask
`else
    task automatic test_mode_ignored();
        bus.i_mode   = 1'b1;
        bus.i_valid  = 1'b1;
        bus.i_binary = 2'd1;
        tick();
        tests_run++;
        if ({bus.o_one_hot, bus.o_ready} !== 5'b0010_1) begin tests_failed++; $display("FAIL mode_ignored_first: got %b expected 00101", {bus.o_one_hot, bus.o_ready}); end
        bus.i_binary = 2'd3;
        tick();
        bus.i_valid  = 1'b0;
        tests_run++;
        if (bus.o_one_hot !== 4'b1000) begin tests_failed++; $display("FAIL mode_ignored_one_hot: got %b expected 1000", bus.o_one_hot); end
        tests_run++;
        if ({bus.o_ready, bus.o_step, bus.o_wrap} !== 3'b100) begin tests_failed++; $display("FAIL mode_ignored_flags: got %b expected 100", {bus.o_ready, bus.o_step, bus.o_wrap}); end
    endtask

    task automatic test_reset_async();
        #2;
        i_rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.o_one_hot, bus.o_index} !== 6'b0000_00) begin tests_failed++; $display("FAIL async_reset: got %b expected 000000", {bus.o_one_hot, bus.o_index}); end
        i_rst_n = 1'b1;
        tick();
        tests_run++;
        if (bus.o_one_hot !== 4'b0001) begin tests_failed++; $display("FAIL after_reset_one_hot: got %b expected 0001", bus.o_one_hot); end
    endtask
`endif

    initial begin
        test_reset();
        test_direct();
        test_idle_ignore();
`ifdef DECODER_SCAN_EN
        test_scan_wrap();
        test_scan_ignore();
        test_disable_mid_dwell();
        test_reset_mid_scan();
`else
        test_mode_ignored();
        test_reset_async();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/decoder_scan_n.md
DECODER_SCAN_N -- requirements
Module: decoder_scan_n

Interface
REQ-001 Parameter BIN_W, default 2, binary select width; legal range 1..8.
REQ-002 Parameter DWELL, default 4, cycles each scan position is held; legal range 1..65535.
REQ-003 Derived localparam OUT_W = 2**BIN_W, one-hot output width; not overridable.
REQ-004 i_clk  in  1  single clock; all state updates on rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_enable  in  1  1 = block active, 0 = force IDLE with outputs blanked.
REQ-007 i_mode  in  1  0 = direct decode, 1 = auto-scan.
REQ-008 i_valid  in  1  i_binary holds a select request.
REQ-009 o_ready  out  1  block accepts a select this cycle.
REQ-010 i_binary  in  BIN_W  requested select index.
REQ-011 o_one_hot  out  OUT_W  registered one-hot decode of current index, or all-zero.
REQ-012 o_index  out  BIN_W  current index register.
REQ-013 o_step  out  1  one-cycle pulse on each scan advance.
REQ-014 o_wrap  out  1  one-cycle pulse when scan advances from OUT_W-1 to 0.

Function
REQ-015 FSM states IDLE, DIRECT, SCAN; state, index, dwell counter are registers.
REQ-016 Transitions, evaluated each edge with this priority: !i_enable -> IDLE; else IDLE -> DIRECT if !i_mode, IDLE -> SCAN if i_mode; DIRECT -> SCAN if i_mode; SCAN -> DIRECT if !i_mode; otherwise hold.
REQ-017 o_ready = 1 only in state DIRECT (combinational from state); 0 in IDLE and SCAN.
REQ-018 Accept = i_valid & o_ready & i_enable & !i_mode; on accept, index <= i_binary at that edge.
REQ-019 Latency: accepted select visible on o_index and o_one_hot the cycle after the accepting edge (1 cycle).
REQ-020 o_one_hot = 1 << index in DIRECT and SCAN; all-zero in IDLE; exactly one bit set in non-IDLE states.
REQ-021 Entering IDLE retains the index; re-entering DIRECT or SCAN resumes from the retained index.
REQ-022 Entering SCAN clears the dwell counter; scan starts at the current index, held DWELL cycles.
REQ-023 In SCAN the dwell counter increments each cycle; at DWELL-1 it clears, index <= index+1 mod OUT_W, o_step pulses.
REQ-024 Wrap: advance from OUT_W-1 to 0 also pulses o_wrap in the same cycle as o_step.
REQ-025 DWELL=1: index advances every cycle in SCAN, o_step continuously high.
REQ-026 i_valid in IDLE or SCAN is ignored; no request is queued.
REQ-027 Leaving SCAN mid-dwell discards the partial dwell count; no o_step for the aborted position.
REQ-028 o_step and o_wrap are 0 outside SCAN.

Reset
REQ-029 Assertion of i_rst_n=0 immediately forces state IDLE, index 0, dwell counter 0, regardless of the clock.
REQ-030 During reset: o_one_hot=0, o_index=0, o_ready=0, o_step=0, o_wrap=0.
REQ-031 First state transition occurs at the first rising edge after i_rst_n deasserts.

Configuration
REQ-032 Macro DECODER_SCAN_EN defined: SCAN state, dwell counter, o_step, o_wrap are implemented per REQ-022..REQ-028.
REQ-033 Macro DECODER_SCAN_EN undefined: no SCAN state or dwell counter; i_mode is treated as 0; o_step and o_wrap are tied 0; all other behaviour is unchanged.

Verification (BIN_W=2, DWELL=3, DECODER_SCAN_EN defined unless noted)
REQ-034 Reset mid-scan at index 2 -> o_one_hot=0000, o_index=0 immediately, without a clock edge.
REQ-035 enable=1, mode=0; then valid with i_binary=0,1,2,3 on consecutive cycles -> o_one_hot 0001,0010,0100,1000, each one cycle after acceptance.
REQ-036 mode=1 from index 3 -> o_one_hot 1000 for 3 cycles, then 0001 with o_step=1 and o_wrap=1 in the same cycle.
REQ-037 Mid-dwell i_enable=0 at index 1, then enable=1 with mode=1 -> output 0000 while disabled, then 0010 for a full 3 cycles.
REQ-038 Valid with i_binary=2 in SCAN and in IDLE -> o_ready=0, index unchanged, no accept.
REQ-039 DECODER_SCAN_EN undefined, mode=1, valid with i_binary=3 -> state DIRECT, o_one_hot=1000, o_step=o_wrap=0.
